// File: rtl/rfphoenix_vec_wb_arbiter.sv
// rfphoenix_vec_wb_arbiter: vector register-file writeback front-end.
// Buffers results from two producers in per-source FIFOs, arbitrates
// round-robin between the FIFO heads and drives one registered write per cycle.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s0_* (valid/ready/thread/reg/mask/data)  source 0 (vector ALU/FPU) push port
//   s1_* (same)                    source 1 (load unit) push port
//   wr, wthread, wa, wmask, wdata  registered register-file write port
//   wsrc                           source of the current write
// Optional (macro RFPHOENIX_WB_PENDING_EN):
//   q_thread, q_reg -> q_pending   combinational in-flight hazard query
module rfphoenix_vec_wb_arbiter #(
  parameter int unsigned NLANES = 16,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned TID_W  = 4,
  parameter int unsigned RID_W  = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [TID_W-1:0]         s0_thread,
  input  logic [RID_W-1:0]         s0_reg,
  input  logic [NLANES*4-1:0]      s0_mask,
  input  logic [NLANES*LANE_W-1:0] s0_data,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic [TID_W-1:0]         s1_thread,
  input  logic [RID_W-1:0]         s1_reg,
  input  logic [NLANES*4-1:0]      s1_mask,
  input  logic [NLANES*LANE_W-1:0] s1_data,
  output logic                     wr,
  output logic [TID_W-1:0]         wthread,
  output logic [RID_W-1:0]         wa,
  output logic [NLANES*4-1:0]      wmask,
  output logic [NLANES*LANE_W-1:0] wdata,
  output logic                     wsrc
`ifdef RFPHOENIX_WB_PENDING_EN
  ,
  input  logic [TID_W-1:0]         q_thread,
  input  logic [RID_W-1:0]         q_reg,
  output logic                     q_pending
`endif
);

  localparam int unsigned MASK_W = NLANES * 4;
  localparam int unsigned DATA_W = NLANES * LANE_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [TID_W-1:0]  thread;
    logic [RID_W-1:0]  rid;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           r_mem [2][DEPTH];
  logic [PTR_W-1:0] r_wp  [2];
  logic [PTR_W-1:0] r_rp  [2];
  logic [CNT_W-1:0] r_cnt [2];
  logic             r_last;

  entry_t           w_in   [2];
  entry_t           w_head [2];
  entry_t           w_sel;
  logic [1:0]       w_valid;
  logic [1:0]       w_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_ne;
  logic             w_gnt;
  logic             w_gsel;

  assign w_in[0]  = {s0_thread, s0_reg, s0_mask, s0_data};
  assign w_in[1]  = {s1_thread, s1_reg, s1_mask, s1_data};
  assign s0_ready = w_ready[0];
  assign s1_ready = w_ready[1];

  // Handshake, FIFO heads and round-robin grant.
  always_comb begin
    w_valid = {s1_valid, s0_valid};
    w_ready = '0;
    w_push  = '0;
    w_ne    = '0;
    for (int i = 0; i < 2; i++) begin
      w_ready[i] = !rst && (r_cnt[i] != CNT_W'(DEPTH));
      w_push[i]  = w_valid[i] && w_ready[i];
      w_ne[i]    = (r_cnt[i] != '0);
      w_head[i]  = r_mem[i][r_rp[i]];
    end
    w_gnt  = |w_ne;
    // Both pending: take the one not served last; otherwise whichever is present.
    w_gsel = (&w_ne) ? ~r_last : w_ne[1];
    w_pop  = {w_gnt && w_gsel, w_gnt && !w_gsel};
    w_sel  = w_gsel ? w_head[1] : w_head[0];
  end

  // FIFO storage; contents need no reset since occupancy is tracked by r_cnt.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wp[i]] <= w_in[i];
    end
  end

  // FIFO pointers, round-robin state and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_last  <= 1'b1;
      wr      <= 1'b0;
      wthread <= '0;
      wa      <= '0;
      wmask   <= '0;
      wdata   <= '0;
      wsrc    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + PTR_W'(1);
        if (w_pop[i])  r_rp[i] <= r_rp[i] + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      if (w_gnt) begin
        r_last  <= w_gsel;
        // An all-zero mask consumes its slot but produces no write strobe.
        wr      <= |w_sel.mask;
        wthread <= w_sel.thread;
        wa      <= w_sel.rid;
        wmask   <= w_sel.mask;
        wdata   <= w_sel.data;
        wsrc    <= w_gsel;
      end else begin
        wr    <= 1'b0;
        wmask <= '0;
      end
    end
  end

`ifdef RFPHOENIX_WB_PENDING_EN
  logic [PTR_W-1:0] w_off;

  // Match the query against every occupied FIFO slot and the live write.
  always_comb begin
    q_pending = 1'b0;
    w_off     = '0;
    if (!rst) begin
      if (wr && (wthread == q_thread) && (wa == q_reg)) q_pending = 1'b1;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          w_off = PTR_W'(j) - r_rp[i];
          if ((CNT_W'(w_off) < r_cnt[i]) &&
              (r_mem[i][j].thread == q_thread) && (r_mem[i][j].rid == q_reg))
            q_pending = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rfphoenix_vec_wb_arbiter.sv
// Self-checking bench for rfphoenix_vec_wb_arbiter: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_rfphoenix_vec_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [3:0]   t;
    logic [5:0]   r;
    logic [63:0]  m;
    logic [511:0] d;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         s0_valid, s1_valid;
  logic         s0_ready, s1_ready;
  logic [3:0]   s0_thread, s1_thread;
  logic [5:0]   s0_reg, s1_reg;
  logic [63:0]  s0_mask, s1_mask;
  logic [511:0] s0_data, s1_data;
  logic         wr;
  logic [3:0]   wthread;
  logic [5:0]   wa;
  logic [63:0]  wmask;
  logic [511:0] wdata;
  logic         wsrc;
`ifdef RFPHOENIX_WB_PENDING_EN
  logic [3:0]   q_thread;
  logic [5:0]   q_reg;
  logic         q_pending;
`endif

  always #5 clk = ~clk;

  rfphoenix_vec_wb_arbiter #(
    .NLANES(16), .LANE_W(32), .TID_W(4), .RID_W(6), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_thread(s0_thread),
    .s0_reg(s0_reg), .s0_mask(s0_mask), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_thread(s1_thread),
    .s1_reg(s1_reg), .s1_mask(s1_mask), .s1_data(s1_data),
    .wr(wr), .wthread(wthread), .wa(wa), .wmask(wmask), .wdata(wdata),
    .wsrc(wsrc)
`ifdef RFPHOENIX_WB_PENDING_EN
    , .q_thread(q_thread), .q_reg(q_reg), .q_pending(q_pending)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: two plain queues plus the expected write-port contents.
  ent_t         mq0[$];
  ent_t         mq1[$];
  bit           m_last = 1'b1;
  logic         e_wr   = 1'b0;
  logic [3:0]   e_thr  = '0;
  logic [5:0]   e_wa   = '0;
  logic [63:0]  e_mask = '0;
  logic [511:0] e_data = '0;
  logic         e_src  = 1'b0;
  logic [3:0]   nq_thread = '0;
  logic [5:0]   nq_reg    = '0;

  function automatic bit model_pending(input logic [3:0] t, input logic [5:0] r);
    bit hit;
    hit = e_wr && (e_thr == t) && (e_wa == r);
    foreach (mq0[k]) if (mq0[k].t == t && mq0[k].r == r) hit = 1'b1;
    foreach (mq1[k]) if (mq1[k].t == t && mq1[k].r == r) hit = 1'b1;
    return hit;
  endfunction

  // One clock: check DUT state after the last edge, drive the next inputs,
  // and advance the model to what the coming edge should produce.
  task automatic cycle(input bit r, input bit v0, input ent_t a, input bit v1, input ent_t b,
                       output bit acc0, output bit acc1);
    ent_t h;
    bit   have0, have1, g;
    @(negedge clk);
    check("wr", 512'(wr), 512'(e_wr));
    check("wmask", 512'(wmask), 512'(e_mask));
    check("wthread", 512'(wthread), 512'(e_thr));
    check("wa", 512'(wa), 512'(e_wa));
    check("wdata", wdata, e_data);
    check("wsrc", 512'(wsrc), 512'(e_src));
    check("s0_ready", 512'(s0_ready), 512'(!rst && (mq0.size() != DEPTH)));
    check("s1_ready", 512'(s1_ready), 512'(!rst && (mq1.size() != DEPTH)));
`ifdef RFPHOENIX_WB_PENDING_EN
    check("q_pending", 512'(q_pending), 512'(!rst && model_pending(q_thread, q_reg)));
    q_thread = nq_thread;
    q_reg    = nq_reg;
`endif
    rst       = r;
    s0_valid  = v0;  s0_thread = a.t; s0_reg = a.r; s0_mask = a.m; s0_data = a.d;
    s1_valid  = v1;  s1_thread = b.t; s1_reg = b.r; s1_mask = b.m; s1_data = b.d;
    acc0 = v0 && !r && (mq0.size() < DEPTH);
    acc1 = v1 && !r && (mq1.size() < DEPTH);
    if (r) begin
      mq0.delete();
      mq1.delete();
      m_last = 1'b1;
      e_wr = 1'b0; e_thr = '0; e_wa = '0; e_mask = '0; e_data = '0; e_src = 1'b0;
    end else begin
      have0 = mq0.size() > 0;
      have1 = mq1.size() > 0;
      if (have0 || have1) begin
        g = (have0 && have1) ? !m_last : have1;
        h = g ? mq1.pop_front() : mq0.pop_front();
        m_last = g;
        e_wr = |h.m; e_mask = h.m; e_thr = h.t; e_wa = h.r; e_data = h.d; e_src = g;
      end else begin
        e_wr = 1'b0;
        e_mask = '0;
      end
      if (acc0) mq0.push_back(a);
      if (acc1) mq1.push_back(b);
    end
  endtask

  function automatic ent_t rnd_ent(input bit allow_zero_mask);
    ent_t e;
    e.t = 4'($urandom_range(0, 3));
    e.r = 6'($urandom_range(0, 3));
    e.m = {$urandom, $urandom};
    if (e.m == '0 || (allow_zero_mask && $urandom_range(0, 7) == 0)) e.m = allow_zero_mask ? '0 : 64'h1;
    for (int k = 0; k < 16; k++) e.d[k*32 +: 32] = $urandom;
    return e;
  endfunction

  function automatic ent_t mk_ent(input logic [3:0] t, input logic [5:0] r, input logic [63:0] m);
    ent_t e;
    e.t = t; e.r = r; e.m = m;
    for (int k = 0; k < 16; k++) e.d[k*32 +: 32] = 32'(k) + 32'(r) * 32'h100;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t z, a, sat0[8], sat1[8];
    bit   a0, a1;
    int   sent0, sent1;
    logic [511:0] lanes;

    z = '0;
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_thread = '0; s0_reg = '0; s0_mask = '0; s0_data = '0;
    s1_thread = '0; s1_reg = '0; s1_mask = '0; s1_data = '0;
`ifdef RFPHOENIX_WB_PENDING_EN
    q_thread = '0; q_reg = '0;
`endif

    // Reset then idle.
    repeat (2) cycle(1, 0, z, 0, z, a0, a1);
    repeat (6) cycle(0, 0, z, 0, z, a0, a1);

    // Single src0 push: write visible after the second edge.
    a = '0;
    a.t = 4'd3; a.r = 6'd10; a.m = '1;
    for (int k = 0; k < 16; k++) a.d[k*32 +: 32] = 32'(k);
    lanes = a.d;
    cycle(0, 1, a, 0, z, a0, a1);
    cycle(0, 0, z, 0, z, a0, a1);
    @(posedge clk); #1;
    check("lat_wr", 512'(wr), 512'(1));
    check("lat_wthread", 512'(wthread), 512'(3));
    check("lat_wa", 512'(wa), 512'(10));
    check("lat_wsrc", 512'(wsrc), 512'(0));
    check("lat_wdata", wdata, lanes);
    repeat (3) cycle(0, 0, z, 0, z, a0, a1);

    // Both sources saturated with 8 entries each.
    for (int k = 0; k < 8; k++) begin
      sat0[k] = mk_ent(4'(k), 6'(k), '1);
      sat1[k] = mk_ent(4'(k + 8), 6'(k + 32), '1);
    end
    sent0 = 0; sent1 = 0;
    for (int c = 0; c < 200 && (sent0 < 8 || sent1 < 8); c++) begin
      cycle(0, sent0 < 8, sat0[sent0 & 7], sent1 < 8, sat1[sent1 & 7], a0, a1);
      if (a0) sent0++;
      if (a1) sent1++;
    end
    check("sat_accepted", 512'(sent0 + sent1), 512'(16));
    repeat (12) cycle(0, 0, z, 0, z, a0, a1);

    // Zero-mask entry sandwiched between two src1 writes.
    cycle(0, 0, z, 1, mk_ent(4'd1, 6'd1, '1), a0, a1);
    cycle(0, 0, z, 1, mk_ent(4'd1, 6'd2, '0), a0, a1);
    cycle(0, 0, z, 1, mk_ent(4'd1, 6'd3, '1), a0, a1);
    repeat (5) cycle(0, 0, z, 0, z, a0, a1);

    // Fill both FIFOs, then reset mid-drain.
    repeat (6) cycle(0, 1, rnd_ent(0), 1, rnd_ent(0), a0, a1);
    cycle(0, 0, z, 0, z, a0, a1);
    cycle(1, 1, rnd_ent(0), 1, rnd_ent(0), a0, a1);
    repeat (10) cycle(0, 0, z, 0, z, a0, a1);

    // Pending query for {2,5}, then a non-matching query {2,6}.
    nq_thread = 4'd2; nq_reg = 6'd5;
    cycle(0, 0, z, 0, z, a0, a1);
    cycle(0, 1, mk_ent(4'd2, 6'd5, '1), 0, z, a0, a1);
    repeat (5) cycle(0, 0, z, 0, z, a0, a1);
    nq_reg = 6'd6;
    cycle(0, 0, z, 0, z, a0, a1);
    cycle(0, 1, mk_ent(4'd2, 6'd5, '1), 0, z, a0, a1);
    repeat (5) cycle(0, 0, z, 0, z, a0, a1);

    // Randomized traffic with occasional resets and zero masks.
    for (int c = 0; c < 600; c++) begin
      nq_thread = 4'($urandom_range(0, 3));
      nq_reg    = 6'($urandom_range(0, 3));
      cycle(($urandom_range(0, 59) == 0), $urandom_range(0, 2) != 0, rnd_ent(1),
            $urandom_range(0, 2) != 0, rnd_ent(1), a0, a1);
    end
    rst = 1'b0;
    repeat (12) cycle(0, 0, z, 0, z, a0, a1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
